imem_loader: RTL
================

# imem_loader

Byte-stream program loader that fills the processor's 256 x 16-bit instruction memory before execution. It sits between an external byte source (a UART receiver or testbench) and the instruction memory write port. It is the writer for the instruction-fetch reader. While loading, it holds the processor via `cpu_hold`, then releases it once the image is complete and valid.

## Interface
- `ADDR_W`, default 8: instruction memory address width (depth 2^ADDR_W = 256 words)
- `WORD_W`, default 16: instruction word width; fixed at 16, two bytes per word
- `clk`  in  1: single clock; all state changes on rising edge
- `rst`  in  1: asynchronous, active-high reset
- `in_byte`  in  8: incoming stream byte
- `in_valid`  in  1: `in_byte` is valid
- `in_ready`  out  1: loader can accept a byte; a transfer occurs when `in_valid && in_ready` at a rising edge
- `reload`  in  1: in DONE only, restarts loading; ignored in all other states
- `imem_we`  out  1: single-cycle instruction memory write strobe
- `imem_addr`  out  ADDR_W: write address
- `imem_wdata`  out  16: write data
- `cpu_hold`  out  1: high keeps the PC frozen at 0; low lets the processor run
- `done`  out  1: image loaded successfully (level)
- `err`  out  1: image rejected (level, sticky until reset)

## Operation
- Stream format:
  - Word count N as a 16-bit big-endian value (hi byte, then lo byte).
  - Then N words, each sent hi byte then lo byte.
  - Then an optional checksum byte (see Configuration).
- FSM states: LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CKSUM (macro only), DONE, ERR.
- LEN_HI --accept--> LEN_LO.
- LEN_LO --accept--> next state depends on N:
  - N > 256: ERR.
  - N == 0: DONE (or CKSUM).
  - Otherwise: DATA_HI.
- DATA_HI --accept--> DATA_LO. The hi byte is latched into `imem_wdata[15:8]`.
- DATA_LO --accept--> WRITE. The lo byte is latched into `imem_wdata[7:0]`.
- WRITE lasts one cycle:
  - `imem_we` = 1 and `imem_addr` = word index.
  - Next state: DONE (or CKSUM) if index == N-1; otherwise DATA_HI with index+1.
- DONE: `done` = 1 and `cpu_hold` = 0.
  - `reload` = 1 causes: `done` = 0, `cpu_hold` = 1, index = 0, next state LEN_HI.
- ERR: `err` = 1, `cpu_hold` = 1, `in_ready` = 0. Only `rst` exits this state.
- `in_ready` = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CKSUM; 0 in WRITE, DONE and ERR.
- Word index is ADDR_W+1 bits wide so N = 256 is representable. `imem_addr` carries the low ADDR_W bits.
- Addresses are written in ascending order starting at 0. Words at addresses >= N are left untouched.

## Timing
- Reset values:
  - State LEN_HI, index 0.
  - `in_ready` = 1, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_hold` = 1, `done` = 0, `err` = 0.
- Accepting the DATA_LO byte gives `imem_we` = 1 in the next cycle.
- Throughput: one word per 3 cycles (hi, lo, write) when `in_valid` is held high.
- Accepting the last word's lo byte gives `done` = 1 two cycles later (WRITE, then DONE); without the macro.
- `cpu_hold` falls in the same cycle `done` rises.
- `in_valid` low stalls in any accepting state, with no timeout.
- `in_valid` high in WRITE is not a transfer; the byte must be held by the source.
- Reset mid-load returns immediately to LEN_HI with all outputs at reset values. Already-written words are not cleared.
- `reload` and `rst` asserted together: `rst` wins.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined:
  - After the last WRITE (or after LEN_LO when N == 0), the FSM enters CKSUM.
  - CKSUM accepts one byte and compares it to the 8-bit XOR of all data bytes (hi and lo, excluding length bytes), accumulated during DATA_HI/DATA_LO.
  - Match → DONE; mismatch → ERR. The accumulator clears on reset and on `reload`.
- Undefined: no CKSUM state and no accumulator. The last WRITE goes directly to DONE.

## Structure
- Package `imem_loader_pkg`:
  - State enum.
  - `IMEM_DEPTH` = 256.
  - `MAX_WORDS` = 256.
  - `BYTE_W` = 8.
- Sub-module `loader_cksum`: XOR accumulator with `clr`, `en` and `byte` inputs and an 8-bit `sum` output. It is instantiated only under `IMEM_LOADER_CKSUM_EN`.

## Test plan
- Reset release, then bytes 00 02 23 01 60 12 (checksum 50 appended when the macro is defined):
  - Writes [0] = 0x2301 and [1] = 0x6012.
  - `done` = 1 and `cpu_hold` = 0 two cycles after the last byte (macro off).
- Same image with `in_valid` toggled every other cycle: identical writes; `in_ready` = 0 during each WRITE cycle.
- Bytes 01 01: `err` = 1 the cycle after the LEN_LO accept; no `imem_we` pulse; `in_ready` = 0.
- Bytes 00 00: `done` = 1 with no writes (macro on: after checksum byte 00).
- Macro on, image 00 01 A5 5A with checksum FF: `done`. The same image with checksum 00: `err`, `cpu_hold` stays 1.
- `rst` asserted after the first data byte of a 2-word load, then a full 1-word load 00 01 F0 00:
  - Only address 0 is written (= 0xF000).
  - `done` = 1.
  - `reload` then returns `cpu_hold` to 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and limits for the instruction-memory byte-stream loader.
// FSM encoding covers the optional checksum state so every build shares one enum.
package imem_loader_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int MAX_WORDS  = 256;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CKSUM,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/loader_cksum.sv
// Running 8-bit XOR of accepted image bytes; updates the cycle after each enabled byte.
// clr has priority over en; no backpressure, sum is always valid.
module loader_cksum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] data_byte,
  output logic [BYTE_W-1:0] sum
);

  logic [BYTE_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q ^ data_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory, holding the CPU until done.
// One word per 3 cycles; in_ready drops in WRITE/DONE/ERR. Optional trailing checksum: IMEM_LOADER_CKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Largest accepted word count: bounded by both the memory and the loader limit.
  localparam int            LIMIT   = (MAX_WORDS < (1 << ADDR_W)) ? MAX_WORDS : (1 << ADDR_W);
  localparam logic [15:0]   MAX_N   = 16'(LIMIT);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [BYTE_W-1:0]   len_hi_q, len_hi_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic                accept;
  logic [15:0]         n_word;
  state_e              end_st;
  logic                cksum_ok;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [BYTE_W-1:0]   sum;
  logic                sum_clr;
  logic                sum_en;

  assign sum_clr = (state_q == ST_DONE) && reload;
  assign sum_en  = accept && ((state_q == ST_DATA_HI) || (state_q == ST_DATA_LO));

  loader_cksum u_cksum (
    .clk       (clk),
    .rst       (rst),
    .clr       (sum_clr),
    .en        (sum_en),
    .data_byte (in_byte),
    .sum       (sum)
  );

  assign end_st   = ST_CKSUM;
  assign cksum_ok = (in_byte == sum);
`else
  assign end_st   = ST_DONE;
  assign cksum_ok = 1'b1;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CKSUM: in_ready = 1'b1;
      default:                                                in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign n_word = {len_hi_q, in_byte};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    len_hi_d = len_hi_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = in_byte;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          if (n_word > MAX_N) begin
            state_d = ST_ERR;
          end else if (n_word == 16'd0) begin
            state_d = end_st;
          end else begin
            len_d   = n_word[ADDR_W:0];
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          wdata_d = {in_byte, wdata_q[BYTE_W-1:0]};
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          wdata_d = {wdata_q[WORD_W-1:BYTE_W], in_byte};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // idx stays on the last address after the final write; reload clears it.
        if (idx_q == len_q - IDX_ONE) begin
          state_d = end_st;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_DATA_HI;
        end
      end
      ST_CKSUM: begin
        if (accept) begin
          state_d = cksum_ok ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE: begin
        if (reload) begin
          idx_d   = '0;
          state_d = ST_LEN_HI;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_LEN_HI;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_LEN_HI;
      idx_q    <= '0;
      len_q    <= '0;
      len_hi_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      len_hi_q <= len_hi_d;
      wdata_q  <= wdata_d;
    end
  end

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = idx_q[ADDR_W-1:0];
  assign imem_wdata = wdata_q;
  assign done       = (state_q == ST_DONE);
  assign cpu_hold   = ~done;
  assign err        = (state_q == ST_ERR);

endmodule
